program_counter16: RTL
======================

// Module: program_counter16
// PURPOSE
//  Instruction-address register with increment, load, call/return and a small
//  return-address stack. Sits upstream of reg16bit/instruction memory: drives
//  the fetch address each cycle and is the control-flow stage of the CPU
//  datapath, fed by the jump logic.
// PARAMETERS
//  WIDTH   16  address/data width in bits
//  DEPTH   4   return-stack entries (power of two, >=2)
// PORTS
//  clk     input   1      common_clock output; all state updates on rising edge
//  rst_n   input   1      asynchronous, active-low reset
//  in      input   WIDTH  jump/call target
//  load    input   1      jump: out <= in
//  inc     input   1      advance: out <= out + 1
//  call    input   1      out <= in, push out+1 onto stack
//  ret     input   1      out <= top of stack, pop
//  clr     input   1      synchronous clear of pc and stack
//  stall   input   1      freeze all state except clr
//  out     output  WIDTH  current pc (registered)
//  depth   output  clog2(DEPTH)+1  stack occupancy 0..DEPTH
//  err     output  1      sticky stack fault (only with PC_STACK_ERR_EN)
// BEHAVIOUR
//  - Reset (rst_n=0, any time, mid-operation included): out=0, depth=0,
//    all stack entries=0, err=0. Takes effect immediately.
//  - One action per edge, priority: clr > stall > ret > call > load > inc > hold.
//  - Latency: controls sampled at edge N; out shows result after edge N.
//  - clr: out=0, depth=0; err cleared; stack contents don't-care.
//  - stall: out, depth, stack, err unchanged; lower controls ignored.
//  - inc: out+1 mod 2^WIDTH; 16'hFFFF -> 16'h0000, no flag.
//  - load: out=in; stack untouched.
//  - call: push (out+1) mod 2^WIDTH, then out=in.
//    Not full: depth+1.
//    Full (depth=DEPTH): oldest entry overwritten (circular); depth stays DEPTH.
//  - ret, depth>0: out=top entry, depth-1.
//    ret, depth=0 (underflow): out and depth unchanged.
//  - Simultaneous call+ret: ret wins, call ignored; same for any lower-priority
//    control asserted together with a higher one.
//  - Stack is LIFO, implemented as circular buffer with top pointer:
//    push writes top+1, pop reads top.
//  - out, depth: registered outputs, never combinational from inputs.
// CONFIGURATION
//  PC_STACK_ERR_EN defined:
//    err port present.
//    err set on call when depth=DEPTH (overflow) or ret when depth=0
//    (underflow). Stays 1 until rst_n=0 or clr. Pc/stack behaviour identical.
//  PC_STACK_ERR_EN undefined:
//    No err port, no err register. Overflow/underflow silently handled as above.
// TESTING  (DEPTH=4, WIDTH=16; dump to ./test_results/PROGRAM_COUNTER16.vcd)
//  1. Reset 0, inc x3 -> out 1,2,3.
//     rst_n=0 mid-cycle -> out=0 immediately, before next edge.
//  2. load in=16'hFFFE, inc x2 -> out FFFE, FFFF, 0000 (wrap).
//  3. out=10, call in=100 -> out=100, depth=1.
//     inc -> 101.
//     ret -> out=11, depth=0.
//  4. 5 calls (in=200,300,400,500,600) from out=0 -> depth=4, err=1 (ERR_EN).
//     4 rets -> 501,401,301,201.
//     5th ret -> out holds 201.
//  5. ret at depth=0 -> out unchanged, err=1.
//     clr -> out=0, err=0.
//  6. stall=1 with inc/load/call/ret -> no change.
//     clr+stall -> out=0.
//     call+ret at depth=1 -> pop only.

Source files
------------

// File: rtl/program_counter16.sv
// Fetch-address register with inc/load/call/ret and a circular return-address stack; optional sticky err via PC_STACK_ERR_EN.
// Latency: controls sampled on a rising edge, out/depth/err updated by that edge (all registered).
// Backpressure: stall freezes all state; clr overrides stall; one action per edge, clr>stall>ret>call>load>inc.
module program_counter16 #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [WIDTH-1:0]         in,
    input  logic                     load,
    input  logic                     inc,
    input  logic                     call,
    input  logic                     ret,
    input  logic                     clr,
    input  logic                     stall,
    output logic [WIDTH-1:0]         out,
    output logic [$clog2(DEPTH):0]   depth
`ifdef PC_STACK_ERR_EN
    ,
    output logic                     err
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0]      FULL = (PW+1)'(DEPTH);
    localparam logic [PW:0]      EMPTY = '0;
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] stack [DEPTH];
    logic [PW-1:0]    top;

    // top always names the most recent push; a push when full overwrites the oldest slot
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out   <= '0;
            depth <= '0;
            top   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                stack[i] <= '0;
            end
        end else if (clr) begin
            out   <= '0;
            depth <= '0;
            top   <= '0;
        end else if (!stall) begin
            if (ret) begin
                if (depth != EMPTY) begin
                    out   <= stack[top];
                    top   <= top - 1'b1;
                    depth <= depth - 1'b1;
                end
            end else if (call) begin
                stack[top + 1'b1] <= out + ONE;
                top               <= top + 1'b1;
                out               <= in;
                if (depth != FULL) begin
                    depth <= depth + 1'b1;
                end
            end else if (load) begin
                out <= in;
            end else if (inc) begin
                out <= out + ONE;
            end
        end
    end

`ifdef PC_STACK_ERR_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else if (clr) begin
            err <= 1'b0;
        end else if (!stall) begin
            if (ret && depth == EMPTY) begin
                err <= 1'b1;
            end else if (!ret && call && depth == FULL) begin
                err <= 1'b1;
            end
        end
    end
`endif

endmodule
